// File: rtl/branch_resolve_if.sv
// Execute-to-predictor bundle: per-lane resolved branches in, update records,
// recovery request and statistics out.
interface branch_resolve_if #(
  parameter int INT_ISSUE_WIDTH = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int PHT_ENTRY_WIDTH = 2,
  parameter int AGE_WIDTH       = 6
);
  localparam int W = INT_ISSUE_WIDTH;

  logic [W-1:0]                 ex_valid;
  logic [W*ADDR_WIDTH-1:0]      ex_br_addr;
  logic [W-1:0]                 ex_exec_taken;
  logic [W*ADDR_WIDTH-1:0]      ex_exec_target;
  logic [W-1:0]                 ex_pred_taken;
  logic [W*ADDR_WIDTH-1:0]      ex_pred_target;
  logic [W*PHT_ENTRY_WIDTH-1:0] ex_pht_prev;
  logic [W-1:0]                 ex_is_approx;
  logic [W*AGE_WIDTH-1:0]       ex_age;

  logic [W-1:0]                 br_valid;
  logic [W*ADDR_WIDTH-1:0]      br_addr;
  logic [W-1:0]                 br_exec_taken;
  logic [W*PHT_ENTRY_WIDTH-1:0] br_pht_prev;
  logic [W-1:0]                 br_is_approx;
  logic                         recover_valid;
  logic [ADDR_WIDTH-1:0]        recover_pc;
  logic                         flushing;
  logic [15:0]                  branch_count;
  logic [15:0]                  mispred_count;

  modport master (
    output ex_valid, ex_br_addr, ex_exec_taken, ex_exec_target, ex_pred_taken,
           ex_pred_target, ex_pht_prev, ex_is_approx, ex_age,
    input  br_valid, br_addr, br_exec_taken, br_pht_prev, br_is_approx,
           recover_valid, recover_pc, flushing, branch_count, mispred_count
  );

  modport slave (
    input  ex_valid, ex_br_addr, ex_exec_taken, ex_exec_target, ex_pred_taken,
           ex_pred_target, ex_pht_prev, ex_is_approx, ex_age,
    output br_valid, br_addr, br_exec_taken, br_pht_prev, br_is_approx,
           recover_valid, recover_pc, flushing, branch_count, mispred_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches from all integer lanes, returns registered predictor updates
// and raises one recovery for the oldest mispredict, then flushes wrong-path results.
module branch_resolve_unit #(
  parameter int INT_ISSUE_WIDTH = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int INSN_BYTE_WIDTH = 4,
  parameter int PHT_ENTRY_WIDTH = 2,
  parameter int AGE_WIDTH       = 6,
  parameter int FLUSH_CYCLES    = 2
) (
  input logic            clk,
  input logic            rst,
  branch_resolve_if.slave bus
);
  localparam int W  = INT_ISSUE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int PW = PHT_ENTRY_WIDTH;
  localparam int GW = AGE_WIDTH;
  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  // Wrapping age compare: a is older when (a - b) has its top bit set.
  function automatic logic is_older(input logic [GW-1:0] a, input logic [GW-1:0] b);
    logic [GW-1:0] d;
    d = a - b;
    return d[GW-1];
  endfunction

  state_t          state;
  logic [CW-1:0]   flush_cnt;
  logic [W-1:0]    mispred;
  logic            found;
  logic [GW-1:0]   m_age;
  logic [AW-1:0]   m_pc;
  logic [W-1:0]    fwd;
  logic [W*AW-1:0] fwd_addr;
  logic [W-1:0]    fwd_taken;
  logic [W*PW-1:0] fwd_pht;
  logic [W-1:0]    fwd_approx;
  logic [16:0]     bc_sum;
  logic [16:0]     mc_sum;

  logic [W-1:0]    br_valid_q;
  logic [W*AW-1:0] br_addr_q;
  logic [W-1:0]    br_taken_q;
  logic [W*PW-1:0] br_pht_q;
  logic [W-1:0]    br_approx_q;
  logic            rec_valid_q;
  logic [AW-1:0]   rec_pc_q;
  logic [15:0]     branch_cnt_q;
  logic [15:0]     mispred_cnt_q;

  // Strictly-older replacement keeps the lower lane on equal ages.
  always_comb begin
    mispred = '0;
    found   = 1'b0;
    m_age   = '0;
    m_pc    = '0;
    for (int i = 0; i < W; i++) begin
      mispred[i] = bus.ex_valid[i] &&
                   ((bus.ex_pred_taken[i] != bus.ex_exec_taken[i]) ||
                    (bus.ex_exec_taken[i] &&
                     (bus.ex_pred_target[i*AW +: AW] != bus.ex_exec_target[i*AW +: AW])));
      if (mispred[i] && (!found || is_older(bus.ex_age[i*GW +: GW], m_age))) begin
        found = 1'b1;
        m_age = bus.ex_age[i*GW +: GW];
        m_pc  = bus.ex_exec_taken[i] ? bus.ex_exec_target[i*AW +: AW]
                                     : bus.ex_br_addr[i*AW +: AW] + AW'(INSN_BYTE_WIDTH);
      end
    end
  end

  always_comb begin
    fwd        = '0;
    fwd_addr   = '0;
    fwd_taken  = '0;
    fwd_pht    = '0;
    fwd_approx = '0;
    bc_sum     = {1'b0, branch_cnt_q};
    mc_sum     = {1'b0, mispred_cnt_q} + 17'd1;
    for (int i = 0; i < W; i++) begin
      fwd[i] = bus.ex_valid[i] && !(found && is_older(m_age, bus.ex_age[i*GW +: GW]));
      if (fwd[i]) begin
        fwd_addr[i*AW +: AW] = bus.ex_br_addr[i*AW +: AW];
        fwd_taken[i]         = bus.ex_exec_taken[i];
        fwd_pht[i*PW +: PW]  = bus.ex_pht_prev[i*PW +: PW];
        fwd_approx[i]        = bus.ex_is_approx[i];
        bc_sum               = bc_sum + 17'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flush_cnt     <= '0;
      br_valid_q    <= '0;
      br_addr_q     <= '0;
      br_taken_q    <= '0;
      br_pht_q      <= '0;
      br_approx_q   <= '0;
      rec_valid_q   <= 1'b0;
      rec_pc_q      <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_valid_q  <= '0;
      br_addr_q   <= '0;
      br_taken_q  <= '0;
      br_pht_q    <= '0;
      br_approx_q <= '0;
      rec_valid_q <= 1'b0;
      rec_pc_q    <= '0;
      case (state)
        IDLE: begin
          br_valid_q   <= fwd;
          br_addr_q    <= fwd_addr;
          br_taken_q   <= fwd_taken;
          br_pht_q     <= fwd_pht;
          br_approx_q  <= fwd_approx;
          branch_cnt_q <= bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
          if (found) begin
            rec_valid_q   <= 1'b1;
            rec_pc_q      <= m_pc;
            mispred_cnt_q <= mc_sum[16] ? 16'hFFFF : mc_sum[15:0];
            if (FLUSH_CYCLES > 0) begin
              state     <= FLUSH;
              flush_cnt <= CW'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == CW'(1)) begin
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.br_valid      = br_valid_q;
  assign bus.br_addr       = br_addr_q;
  assign bus.br_exec_taken = br_taken_q;
  assign bus.br_pht_prev   = br_pht_q;
  assign bus.br_is_approx  = br_approx_q;
  assign bus.recover_valid = rec_valid_q;
  assign bus.recover_pc    = rec_pc_q;
  assign bus.flushing      = (state == FLUSH);
  assign bus.branch_count  = branch_cnt_q;
  assign bus.mispred_count = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit against a per-cycle reference model.
module tb_branch_resolve_unit;
  localparam int W  = 2;
  localparam int AW = 32;
  localparam int PW = 2;
  localparam int GW = 6;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.INT_ISSUE_WIDTH(W), .ADDR_WIDTH(AW), .PHT_ENTRY_WIDTH(PW),
                      .AGE_WIDTH(GW)) bus ();

  branch_resolve_unit #(.INT_ISSUE_WIDTH(W), .ADDR_WIDTH(AW), .INSN_BYTE_WIDTH(4),
                        .PHT_ENTRY_WIDTH(PW), .AGE_WIDTH(GW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edges still to be ignored, and the two statistics counters.
  int rem  = 0;
  int m_bc = 0;
  int m_mc = 0;

  logic [W-1:0]    e_bv;
  logic [W*AW-1:0] e_ba;
  logic [W-1:0]    e_bt;
  logic [W*PW-1:0] e_bp;
  logic [W-1:0]    e_bx;
  logic            e_rv;
  logic [AW-1:0]   e_rpc;
  logic            e_fl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit older(input int a, input int b);
    return (((a - b) % 64) + 64) % 64 >= 32;
  endfunction

  task automatic clear_lanes();
    bus.ex_valid       = '0;
    bus.ex_br_addr     = '0;
    bus.ex_exec_taken  = '0;
    bus.ex_exec_target = '0;
    bus.ex_pred_taken  = '0;
    bus.ex_pred_target = '0;
    bus.ex_pht_prev    = '0;
    bus.ex_is_approx   = '0;
    bus.ex_age         = '0;
  endtask

  task automatic set_lane(input int i, input bit v, input logic [31:0] addr, input bit et,
                          input logic [31:0] etgt, input bit pt, input logic [31:0] ptgt,
                          input logic [1:0] pht, input bit apx, input logic [5:0] age);
    bus.ex_valid[i]             = v;
    bus.ex_br_addr[i*AW +: AW]  = addr;
    bus.ex_exec_taken[i]        = et;
    bus.ex_exec_target[i*AW +: AW] = etgt;
    bus.ex_pred_taken[i]        = pt;
    bus.ex_pred_target[i*AW +: AW] = ptgt;
    bus.ex_pht_prev[i*PW +: PW] = pht;
    bus.ex_is_approx[i]         = apx;
    bus.ex_age[i*GW +: GW]      = age;
  endtask

  // Applies one clock: predicts the outputs from the current inputs, then compares.
  task automatic cycle();
    bit mp [W];
    int age [W];
    int m;
    int nf;
    bit win;
    logic [31:0] a;
    e_bv = '0; e_ba = '0; e_bt = '0; e_bp = '0; e_bx = '0;
    e_rv = 1'b0; e_rpc = '0; e_fl = 1'b0;
    m = -1;
    nf = 0;
    if (rst) begin
      rem = 0; m_bc = 0; m_mc = 0;
    end else if (rem > 0) begin
      rem--;
      e_fl = (rem > 0);
    end else begin
      for (int i = 0; i < W; i++) begin
        age[i] = int'(bus.ex_age[i*GW +: GW]);
        mp[i]  = bus.ex_valid[i] &&
                 ((bus.ex_pred_taken[i] != bus.ex_exec_taken[i]) ||
                  (bus.ex_exec_taken[i] &&
                   bus.ex_pred_target[i*AW +: AW] != bus.ex_exec_target[i*AW +: AW]));
      end
      for (int i = 0; i < W; i++) begin
        if (mp[i] && m < 0) begin
          win = 1'b1;
          for (int j = 0; j < W; j++)
            if (j != i && mp[j] && (older(age[j], age[i]) || (age[j] == age[i] && j < i)))
              win = 1'b0;
          if (win) m = i;
        end
      end
      for (int i = 0; i < W; i++) begin
        if (bus.ex_valid[i] && !(m >= 0 && older(age[m], age[i]))) begin
          e_bv[i]           = 1'b1;
          e_ba[i*AW +: AW]  = bus.ex_br_addr[i*AW +: AW];
          e_bt[i]           = bus.ex_exec_taken[i];
          e_bp[i*PW +: PW]  = bus.ex_pht_prev[i*PW +: PW];
          e_bx[i]           = bus.ex_is_approx[i];
          nf++;
        end
      end
      m_bc = (m_bc + nf > 65535) ? 65535 : m_bc + nf;
      if (m >= 0) begin
        e_rv = 1'b1;
        a = bus.ex_br_addr[m*AW +: AW] + 32'd4;
        e_rpc = bus.ex_exec_taken[m] ? bus.ex_exec_target[m*AW +: AW] : a;
        m_mc = (m_mc + 1 > 65535) ? 65535 : m_mc + 1;
        rem = FC;
      end
      e_fl = (rem > 0);
    end
    @(posedge clk);
    @(negedge clk);
    check("br_valid",      64'(bus.br_valid),      64'(e_bv));
    check("br_addr",       64'(bus.br_addr),       64'(e_ba));
    check("br_exec_taken", 64'(bus.br_exec_taken), 64'(e_bt));
    check("br_pht_prev",   64'(bus.br_pht_prev),   64'(e_bp));
    check("br_is_approx",  64'(bus.br_is_approx),  64'(e_bx));
    check("recover_valid", 64'(bus.recover_valid), 64'(e_rv));
    check("recover_pc",    64'(bus.recover_pc),    64'(e_rpc));
    check("flushing",      64'(bus.flushing),      64'(e_fl));
    check("branch_count",  64'(bus.branch_count),  64'(m_bc));
    check("mispred_count", 64'(bus.mispred_count), 64'(m_mc));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      clear_lanes();
      cycle();
    end
  endtask

  initial begin
    int d;
    int a0;
    bit et;
    logic [31:0] tgt;
    rst = 1'b1;
    clear_lanes();
    cycle();
    cycle();
    check("rst_br_valid", 64'(bus.br_valid), 64'd0);
    check("rst_flushing", 64'(bus.flushing), 64'd0);
    rst = 1'b0;

    // Single correct taken branch.
    clear_lanes();
    set_lane(0, 1, 32'h100, 1, 32'h180, 1, 32'h180, 2'd2, 0, 6'd10);
    cycle();
    check("t1_br_valid", 64'(bus.br_valid), 64'h1);
    check("t1_br_addr0", 64'(bus.br_addr[31:0]), 64'h100);
    check("t1_pht0", 64'(bus.br_pht_prev[1:0]), 64'h2);
    check("t1_branch_count", 64'(bus.branch_count), 64'd1);

    // Direction mispredict, not taken; following results are flushed.
    clear_lanes();
    set_lane(1, 1, 32'h200, 0, 32'h0, 1, 32'h280, 2'd1, 0, 6'd11);
    cycle();
    check("t2_recover_valid", 64'(bus.recover_valid), 64'h1);
    check("t2_recover_pc", 64'(bus.recover_pc), 64'h204);
    check("t2_flushing", 64'(bus.flushing), 64'h1);
    for (int k = 0; k < 3; k++) begin
      clear_lanes();
      set_lane(0, 1, 32'h210, 0, 32'h0, 0, 32'h0, 2'd0, 0, 6'd12);
      set_lane(1, 1, 32'h214, 0, 32'h0, 0, 32'h0, 2'd0, 0, 6'd13);
      cycle();
      check("t2_flush_drop", 64'(bus.br_valid), (k < 2) ? 64'h0 : 64'h3);
    end

    // Dual mispredict, lane1 older.
    clear_lanes();
    set_lane(0, 1, 32'h30, 1, 32'h300, 0, 32'h0, 2'd0, 0, 6'd5);
    set_lane(1, 1, 32'h40, 1, 32'h400, 0, 32'h0, 2'd0, 0, 6'd3);
    cycle();
    check("t3_recover_pc", 64'(bus.recover_pc), 64'h400);
    check("t3_br_valid", 64'(bus.br_valid), 64'h2);
    idle_cycles(2);

    // Age wrap-around: 62 is older than 1.
    clear_lanes();
    set_lane(0, 1, 32'h60, 1, 32'h620, 0, 32'h0, 2'd3, 1, 6'd62);
    set_lane(1, 1, 32'h64, 1, 32'h640, 0, 32'h0, 2'd3, 0, 6'd1);
    cycle();
    check("t4_recover_pc", 64'(bus.recover_pc), 64'h620);
    check("t4_br_valid", 64'(bus.br_valid), 64'h1);
    check("t4_approx", 64'(bus.br_is_approx), 64'h1);
    idle_cycles(2);

    // Target-only mispredict, then fall-through wrap.
    clear_lanes();
    set_lane(0, 1, 32'h50, 1, 32'h540, 1, 32'h500, 2'd2, 0, 6'd20);
    cycle();
    check("t5_recover_pc", 64'(bus.recover_pc), 64'h540);
    idle_cycles(2);
    clear_lanes();
    set_lane(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 2'd1, 0, 6'd21);
    cycle();
    check("t5_wrap_pc", 64'(bus.recover_pc), 64'h0);
    check("t5_wrap_valid", 64'(bus.recover_valid), 64'h1);
    idle_cycles(2);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      clear_lanes();
      a0 = $urandom_range(0, 63);
      d  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 62);
      if (d >= 32) d = d + 1;
      for (int i = 0; i < W; i++) begin
        et  = $urandom_range(0, 1);
        tgt = $urandom & 32'hFFFF_FFFC;
        set_lane(i, $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, et, tgt,
                 ($urandom_range(0, 3) != 0) ? et : !et,
                 ($urandom_range(0, 4) != 0) ? tgt : ($urandom & 32'hFFFF_FFFC),
                 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                 6'((a0 + ((i == 0) ? 0 : d)) % 64));
      end
      cycle();
    end

    // Reset during the second flush cycle.
    idle_cycles(3);
    clear_lanes();
    set_lane(0, 1, 32'h700, 1, 32'h780, 0, 32'h0, 2'd1, 0, 6'd7);
    cycle();
    idle_cycles(1);
    check("rf_in_flush", 64'(bus.flushing), 64'h1);
    rst = 1'b1;
    clear_lanes();
    cycle();
    check("rf_flushing", 64'(bus.flushing), 64'h0);
    check("rf_mispred_count", 64'(bus.mispred_count), 64'h0);
    rst = 1'b0;
    set_lane(0, 1, 32'h800, 0, 32'h0, 0, 32'h0, 2'd0, 0, 6'd8);
    cycle();
    check("rf_accept", 64'(bus.br_valid), 64'h1);

    // Saturation of branch_count.
    for (int c = 0; c < 32768; c++) begin
      clear_lanes();
      set_lane(0, 1, 32'h900, 0, 32'h0, 0, 32'h0, 2'd0, 0, 6'd1);
      set_lane(1, 1, 32'h904, 0, 32'h0, 0, 32'h0, 2'd0, 0, 6'd2);
      cycle();
    end
    check("sat_branch_count", 64'(bus.branch_count), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Sits at the end of the integer execute stage, opposite the bimodal branch predictor. It collects resolved branches from every integer issue lane and sends registered branch-result update records back to the predictor, which uses them to write its pattern table. It also detects mispredictions, picks the oldest one when several arrive in the same cycle, and raises a single recovery request carrying the corrected PC. A small flush FSM then discards wrong-path results until fetch restarts.

## Interface
Parameters:
- INT_ISSUE_WIDTH, 2, number of integer lanes (W)
- ADDR_WIDTH, 32, PC width
- INSN_BYTE_WIDTH, 4, instruction size in bytes for fall-through PC
- PHT_ENTRY_WIDTH, 2, counter width echoed back to predictor
- AGE_WIDTH, 6, wrapping program-order tag width
- FLUSH_CYCLES, 2, cycles results are discarded after a recovery

Ports (flattened per lane, lane i occupies slice i):
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- ex_valid  in  W  resolved branch present on lane
- ex_br_addr  in  W*ADDR_WIDTH  branch PC
- ex_exec_taken  in  W  actual direction
- ex_exec_target  in  W*ADDR_WIDTH  actual taken target
- ex_pred_taken  in  W  direction predicted at fetch
- ex_pred_target  in  W*ADDR_WIDTH  target predicted at fetch
- ex_pht_prev  in  W*PHT_ENTRY_WIDTH  counter value read at fetch
- ex_is_approx  in  W  approximate-branch flag
- ex_age  in  W*AGE_WIDTH  program-order tag
- br_valid  out  W  update record valid
- br_addr  out  W*ADDR_WIDTH  registered ex_br_addr
- br_exec_taken  out  W  registered ex_exec_taken
- br_pht_prev  out  W*PHT_ENTRY_WIDTH  registered ex_pht_prev
- br_is_approx  out  W  registered ex_is_approx
- recover_valid  out  1  one-cycle recovery pulse
- recover_pc  out  ADDR_WIDTH  corrected fetch PC
- flushing  out  1  FSM is in FLUSH
- branch_count  out  16  saturating count of accepted branches
- mispred_count  out  16  saturating count of recoveries

## Operation
- Mispredict on lane i:
  - ex_valid[i] is set, and either
  - ex_pred_taken ≠ ex_exec_taken, or
  - both are taken and ex_pred_target ≠ ex_exec_target.
- Age ordering: a is older than b when bit AGE_WIDTH-1 of (a − b) mod 2^AGE_WIDTH is 1. Equal ages are not allowed on the same cycle; if they occur anyway, the lower lane index wins.
- Oldest-mispredict selection: among the mispredicting lanes in a cycle, select the single oldest, call it m.
- Same-cycle suppression: a lane whose age is younger than m has its result discarded, so br_valid stays 0 for it. Lane m itself and all lanes older than m are forwarded.
- recover_pc for m:
  - ex_exec_target when exec_taken is set;
  - otherwise ex_br_addr + INSN_BYTE_WIDTH, computed modulo 2^ADDR_WIDTH.
- Approximate branches are forwarded with br_is_approx=1; the predictor filters them. They still trigger recovery and are still counted.
- FSM states:
  - IDLE: inputs are accepted. Any mispredict moves to FLUSH, loads the flush counter with FLUSH_CYCLES, and registers the recovery.
  - FLUSH: every ex_valid is ignored, including new mispredicts. The counter decrements each cycle; at 1 → IDLE. With FLUSH_CYCLES=0 the FSM returns to IDLE immediately.
- Counters:
  - branch_count += popcount of forwarded lanes.
  - mispred_count += 1 per recovery.
  - Both saturate at 0xFFFF.
- Reset:
  - All outputs read 0, FSM goes to IDLE, counters clear.
  - Reset asserted during FLUSH aborts the flush; the cycle after reset deasserts is IDLE.

## Timing
- Latency 1: inputs sampled at edge N appear on br_* and recover_* during cycle N+1.
- recover_valid is high for exactly one cycle. flushing is high from that same cycle for FLUSH_CYCLES cycles.
- br_* outputs are 0 on any cycle without a valid forwarded record.
- No backpressure. The predictor must absorb W updates every cycle; its bank-conflict queue handles collisions.

## Test plan
- Single correct branch: lane0 valid, pred=exec=taken, same target, addr 0x100, pht_prev=2 → next cycle br_valid=01, br_addr[0]=0x100, br_pht_prev[0]=2, recover_valid=0, branch_count=1.
- Direction mispredict, not-taken: lane1 addr 0x200, pred taken, exec not-taken → recover_valid=1, recover_pc=0x204, flushing=1 for 2 cycles; lane inputs during those cycles produce br_valid=0.
- Dual mispredict, oldest wins: lane0 age 5 target 0x300, lane1 age 3 target 0x400, both mispredict → recover_pc=0x400, br_valid=10 (lane0 younger, dropped), mispred_count=1.
- Age wrap-around: lane0 age 62, lane1 age 1 (AGE_WIDTH=6), both mispredict → lane0 treated as older, recover_pc from lane0.
- Target-only mispredict: pred/exec both taken, pred target 0x500, exec target 0x540 → recover_pc=0x540. Separately, a fall-through at addr 0xFFFFFFFC yields recover_pc=0x0.
- Reset mid-flush and saturation: assert rst in the second FLUSH cycle → all outputs 0, next cycle IDLE accepts a branch. Preload branch_count to 0xFFFF by driving 65535 branches, then send 2 more → counter stays 0xFFFF.
